// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response, memory and status signals for mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding system (requesters + memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [LINE_WIDTH-1:0] req_wdata0;
    logic [LINE_WIDTH-1:0] req_wdata1;

    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_err;
    logic [LINE_WIDTH-1:0] rsp_rdata;

    logic                  m_rreq_valid;
    logic                  m_rreq_ready;
    logic [ADDR_WIDTH-1:0] m_raddr;
    logic                  m_rrep_valid;
    logic [LINE_WIDTH-1:0] m_rdata;

    logic                  m_wreq_valid;
    logic                  m_wreq_ready;
    logic [ADDR_WIDTH-1:0] m_waddr;
    logic [LINE_WIDTH-1:0] m_wdata;
    logic                  m_wrep_valid;

    logic                  busy;
    logic                  owner;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  m_rreq_ready, m_rrep_valid, m_rdata, m_wreq_ready, m_wrep_valid,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output m_rreq_valid, m_raddr, m_wreq_valid, m_waddr, m_wdata,
        output busy, owner
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output m_rreq_ready, m_rrep_valid, m_rdata, m_wreq_ready, m_wrep_valid,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  m_rreq_valid, m_raddr, m_wreq_valid, m_waddr, m_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding line memory port.
// One transaction at a time: grant in IDLE, request in ISSUE, reply or timeout in WAIT.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-4){1'b1}}, 4'h0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ptr;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_grant;
    logic                  w_grant_en;
    logic                  w_done;
    logic                  w_reply;
    logic [1:0]            w_req_ready;
    logic [1:0]            w_rsp_valid;
    logic [1:0]            w_rsp_err;
    logic [LINE_WIDTH-1:0] w_rsp_rdata;
    logic                  w_rreq_valid;
    logic                  w_wreq_valid;

    // Pointer only breaks ties; a lone requester always wins.
    assign w_grant = (&bus.req_valid) ? r_ptr : bus.req_valid[1];
    assign w_reply = r_we ? bus.m_wrep_valid : bus.m_rrep_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_done       = 1'b0;
        w_req_ready  = '0;
        w_rsp_valid  = '0;
        w_rsp_err    = '0;
        w_rsp_rdata  = '0;
        w_rreq_valid = 1'b0;
        w_wreq_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) begin
                    w_grant_en           = 1'b1;
                    w_req_ready[w_grant] = 1'b1;
                    w_next_state         = ISSUE;
                end
            end
            ISSUE: begin
                w_rreq_valid = ~r_we;
                w_wreq_valid = r_we;
                if (r_we ? bus.m_wreq_ready : bus.m_rreq_ready) w_next_state = WAIT;
            end
            WAIT: begin
                if (w_reply) begin
                    w_rsp_valid[r_owner] = 1'b1;
                    if (!r_we) w_rsp_rdata = bus.m_rdata;
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end else if (r_cnt == CNT_WIDTH'(TIMEOUT)) begin
                    w_rsp_valid[r_owner] = 1'b1;
                    w_rsp_err[r_owner]   = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the latched request is cleared too, since it drives m_raddr/m_waddr/m_wdata directly.
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_grant_en) begin
                r_owner <= w_grant;
                r_we    <= bus.req_we[w_grant];
                r_addr  <= w_grant ? bus.req_addr1  : bus.req_addr0;
                r_wdata <= w_grant ? bus.req_wdata1 : bus.req_wdata0;
            end
            if (w_done) r_ptr <= ~r_owner;
            r_cnt <= (r_state == WAIT) ? r_cnt + CNT_WIDTH'(1) : '0;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.rsp_err      = w_rsp_err;
    assign bus.rsp_rdata    = w_rsp_rdata;
    assign bus.m_rreq_valid = w_rreq_valid;
    assign bus.m_wreq_valid = w_wreq_valid;
    assign bus.m_raddr      = r_addr & ALIGN_MASK;
    assign bus.m_waddr      = r_addr & ALIGN_MASK;
    assign bus.m_wdata      = r_wdata;
    assign bus.busy         = (r_state != IDLE);
    assign bus.owner        = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: read, stray replies, write backpressure,
// timeout, reset mid-transaction and round-robin contention.
module tb_mem_port_arbiter;
    localparam logic [127:0] RD_LINE  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [127:0] RD_LINE2 = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;
    localparam logic [127:0] WR_LINE  = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .LINE_WIDTH(128),
        .TIMEOUT   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.req_valid    = 2'b00;
        bus.req_we       = 2'b00;
        bus.req_addr0    = '0;
        bus.req_addr1    = '0;
        bus.req_wdata0   = '0;
        bus.req_wdata1   = '0;
        bus.m_rreq_ready = 1'b0;
        bus.m_rrep_valid = 1'b0;
        bus.m_rdata      = '0;
        bus.m_wreq_ready = 1'b0;
        bus.m_wrep_valid = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_busy",   bus.busy, 1'b0);
        check("rst_owner",  bus.owner, 1'b0);
        check("rst_rsp",    bus.rsp_valid, 2'b00);
        check("rst_rreq",   bus.m_rreq_valid, 1'b0);
        check("rst_wreq",   bus.m_wreq_valid, 1'b0);
        check("rst_raddr",  bus.m_raddr, 32'h0);
        check("rst_ready",  bus.req_ready, 2'b00);

        // Single read on port 0, reply two cycles after the request handshake
        bus.req_valid    = 2'b01;
        bus.req_addr0    = 32'h0000_0123;
        bus.m_rreq_ready = 1'b1;
        #1;
        check("rd_ready", bus.req_ready, 2'b01);
        tick();
        #1;
        check("rd_issue_rreq",  bus.m_rreq_valid, 1'b1);
        check("rd_issue_wreq",  bus.m_wreq_valid, 1'b0);
        check("rd_raddr",       bus.m_raddr, 32'h0000_0120);
        check("rd_issue_busy",  bus.busy, 1'b1);
        check("rd_issue_ready", bus.req_ready, 2'b00);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("rd_wait_rreq", bus.m_rreq_valid, 1'b0);
        check("rd_wait_rsp",  bus.rsp_valid, 2'b00);
        tick();
        bus.m_rrep_valid = 1'b1;
        bus.m_rdata      = RD_LINE;
        #1;
        check("rd_rsp_valid", bus.rsp_valid, 2'b01);
        check("rd_rsp_rdata", bus.rsp_rdata, RD_LINE);
        check("rd_rsp_err",   bus.rsp_err, 2'b00);
        tick();
        bus.m_rrep_valid = 1'b0;
        #1;
        check("rd_done_busy", bus.busy, 1'b0);
        check("rd_done_rsp",  bus.rsp_valid, 2'b00);

        // Stray read reply while IDLE
        tick();
        bus.m_rrep_valid = 1'b1;
        bus.m_rdata      = RD_LINE2;
        #1;
        check("stray_idle_rsp",  bus.rsp_valid, 2'b00);
        check("stray_idle_busy", bus.busy, 1'b0);
        tick();
        bus.m_rrep_valid = 1'b0;
        #1;
        check("stray_idle_after", bus.busy, 1'b0);

        // Read on port 0 with a stray write reply during WAIT
        bus.req_valid = 2'b01;
        bus.req_addr0 = 32'h1000_0007;
        #1;
        check("stray_rd_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("stray_rd_raddr", bus.m_raddr, 32'h1000_0000);
        tick();
        bus.m_wrep_valid = 1'b1;
        #1;
        check("stray_wrep_rsp", bus.rsp_valid, 2'b00);
        tick();
        bus.m_wrep_valid = 1'b0;
        #1;
        check("stray_wrep_busy", bus.busy, 1'b1);
        check("stray_wrep_rsp2", bus.rsp_valid, 2'b00);
        bus.m_rrep_valid = 1'b1;
        #1;
        check("stray_rd_rsp",   bus.rsp_valid, 2'b01);
        check("stray_rd_rdata", bus.rsp_rdata, RD_LINE2);
        tick();
        bus.m_rrep_valid = 1'b0;
        #1;
        check("stray_rd_done", bus.busy, 1'b0);

        // Write on port 1, m_wreq_ready low for three ISSUE cycles
        bus.req_valid    = 2'b10;
        bus.req_we       = 2'b10;
        bus.req_addr1    = 32'h0000_0040;
        bus.req_wdata1   = WR_LINE;
        bus.m_wreq_ready = 1'b0;
        #1;
        check("wr_ready", bus.req_ready, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req_valid = 2'b00;
            if (i == 3) bus.m_wreq_ready = 1'b1;
            #1;
            check("wr_issue_wreq",  bus.m_wreq_valid, 1'b1);
            check("wr_issue_rreq",  bus.m_rreq_valid, 1'b0);
            check("wr_issue_waddr", bus.m_waddr, 32'h0000_0040);
            check("wr_issue_wdata", bus.m_wdata, WR_LINE);
        end
        tick();
        bus.m_wreq_ready = 1'b0;
        #1;
        check("wr_wait_wreq", bus.m_wreq_valid, 1'b0);
        check("wr_wait_rsp",  bus.rsp_valid, 2'b00);
        tick();
        bus.m_wrep_valid = 1'b1;
        bus.m_rdata      = RD_LINE;
        #1;
        check("wr_rsp_valid", bus.rsp_valid, 2'b10);
        check("wr_rsp_rdata", bus.rsp_rdata, 128'h0);
        check("wr_rsp_err",   bus.rsp_err, 2'b00);
        tick();
        bus.m_wrep_valid = 1'b0;
        bus.req_we       = 2'b00;
        #1;
        check("wr_done_busy",  bus.busy, 1'b0);
        check("wr_done_owner", bus.owner, 1'b1);

        // Read timeout on port 0: eight silent WAIT cycles, then rsp_valid+rsp_err
        bus.req_valid    = 2'b01;
        bus.req_addr0    = 32'h0000_0200;
        bus.m_rreq_ready = 1'b1;
        #1;
        check("to_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("to_issue", bus.m_rreq_valid, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            check("to_wait_rsp", bus.rsp_valid, 2'b00);
        end
        tick();
        #1;
        check("to_rsp_valid", bus.rsp_valid, 2'b01);
        check("to_rsp_err",   bus.rsp_err, 2'b01);
        tick();
        #1;
        check("to_done_busy", bus.busy, 1'b0);
        check("to_done_err",  bus.rsp_err, 2'b00);

        // Reset while port 1 read sits in WAIT; the late reply must be ignored
        bus.req_valid = 2'b10;
        bus.req_addr1 = 32'h0000_0080;
        #1;
        check("rw_ready", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        tick();
        #1;
        check("rw_wait_busy", bus.busy, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rw_rst_busy",  bus.busy, 1'b0);
        check("rw_rst_owner", bus.owner, 1'b0);
        check("rw_rst_rsp",   bus.rsp_valid, 2'b00);
        bus.m_rrep_valid = 1'b1;
        bus.m_rdata      = RD_LINE2;
        #1;
        check("rw_late_rsp", bus.rsp_valid, 2'b00);
        tick();
        bus.m_rrep_valid = 1'b0;
        #1;
        check("rw_late_busy", bus.busy, 1'b0);

        // Contention: both valid throughout, reply in the first WAIT cycle
        bus.req_valid = 2'b11;
        bus.req_addr0 = 32'h0000_1004;
        bus.req_addr1 = 32'h0000_2008;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            #1;
            check("rr_owner", bus.owner, (k % 2 == 0) ? 1'b0 : 1'b1);
            check("rr_raddr", bus.m_raddr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            check("rr_issue_ready", bus.req_ready, 2'b00);
            tick();
            bus.m_rrep_valid = 1'b1;
            #1;
            check("rr_rsp", bus.rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_return_ready", bus.req_ready, 2'b00);
            tick();
            bus.m_rrep_valid = 1'b0;
        end
        bus.req_valid = 2'b00;
        #1;
        check("rr_end_busy", bus.busy, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: requester/memory address width in bits.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: cache-line data width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for a memory reply.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid/req_ready/req_we, input/output/input, [1:0]: per-requester handshake and write flag; port 0 is instruction refill, port 1 is data.
REQ-007 SHALL have ports req_addr0/req_addr1, input, ADDR_WIDTH: request byte addresses.
REQ-008 SHALL have ports req_wdata0/req_wdata1, input, LINE_WIDTH: write lines.
REQ-009 SHALL have ports rsp_valid/rsp_err, output, [1:0]: per-requester one-cycle completion and timeout pulses.
REQ-010 SHALL have port rsp_rdata, output, LINE_WIDTH: read line, shared by both requesters and qualified by rsp_valid.
REQ-011 SHALL have ports m_rreq_valid (output, 1), m_rreq_ready (input, 1), m_raddr (output, ADDR_WIDTH): memory read-request channel.
REQ-012 SHALL have ports m_rrep_valid (input, 1), m_rdata (input, LINE_WIDTH): memory read-reply channel.
REQ-013 SHALL have ports m_wreq_valid (output, 1), m_wreq_ready (input, 1), m_waddr (output, ADDR_WIDTH), m_wdata (output, LINE_WIDTH), m_wrep_valid (input, 1): memory write channels.
REQ-014 SHALL have ports busy (output, 1) and owner (output, 1): a transaction is in flight, and the index of the granted requester.

Function
REQ-015 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-016 IDLE: if any req_valid is set, SHALL grant one requester, assert that requester's req_ready combinationally in the same cycle, latch its we, addr and wdata, and go to ISSUE; req_ready SHALL be 0 in every other state.
REQ-017 Arbitration SHALL be round-robin via a 1-bit priority pointer; when both requesters are valid, the requester indexed by the pointer wins; when only one is valid, it wins regardless of the pointer.
REQ-018 After each completed transaction, the pointer SHALL be set to the non-owner; a lone requester SHALL NOT be starved or delayed by the pointer.
REQ-019 ISSUE: SHALL hold m_rreq_valid (read) or m_wreq_valid (write) high, together with the latched address/data, until the matching ready is sampled high, then go to WAIT.
REQ-020 Address alignment: m_raddr and m_waddr SHALL have bits [3:0] forced to 0; the upper bits SHALL come from the latched address.
REQ-021 WAIT: on the matching m_rrep_valid or m_wrep_valid, rsp_valid[owner] SHALL pulse in the same cycle, with rsp_rdata = m_rdata for a read and 0 for a write; the FSM then returns to IDLE.
REQ-022 WAIT: a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT with no reply, rsp_valid[owner] and rsp_err[owner] SHALL pulse together, and the FSM returns to IDLE.
REQ-023 Reply signals SHALL be ignored outside WAIT; a reply of the wrong type (a write reply during a read, or vice versa) SHALL be ignored.
REQ-024 A new grant SHALL NOT occur in the cycle the FSM returns to IDLE; the earliest back-to-back grant is the following cycle.
REQ-025 Only one memory request SHALL be outstanding at a time; m_rreq_valid and m_wreq_valid SHALL never be high together.
REQ-026 busy SHALL be 1 in ISSUE and WAIT and 0 otherwise; owner SHALL hold the last grant index.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE, the pointer and counter SHALL clear to 0, and all outputs SHALL be 0 from the next cycle.
REQ-028 A rst mid-transaction SHALL abandon the transaction without issuing any rsp_valid; a memory reply arriving after reset SHALL be ignored.

Verification
REQ-029 Single read: req_valid=01, addr0=0x0000_0123, m_rreq_ready=1, reply 2 cycles later with m_rdata=0xDEAD...BEEF -> m_raddr=0x0000_0120, rsp_valid=01 in the reply cycle, rsp_rdata=0xDEAD...BEEF.
REQ-030 Contention: req_valid=11 held continuously, each memory reply after 1 cycle -> grant order 0,1,0,1, with no grant in any return-to-IDLE cycle.
REQ-031 Write with backpressure: req_valid=10, we=1, addr1=0x40, m_wreq_ready low for 3 cycles -> m_wreq_valid held 4 cycles with stable m_waddr=0x40 and m_wdata; rsp_valid=10 on m_wrep_valid.
REQ-032 Timeout, TIMEOUT=8: read issued and no reply -> after 8 WAIT cycles, rsp_valid=01 and rsp_err=01 pulse; busy=0 the next cycle.
REQ-033 Reset in WAIT: assert rst for 1 cycle, then pulse m_rrep_valid -> rsp_valid stays 00; the next request is granted to port 0 (pointer reset).
REQ-034 Stray reply: m_rrep_valid pulsed in IDLE, and m_wrep_valid pulsed during a read WAIT -> no rsp_valid, no state change.
